// File: rtl/bht_pkg.sv
// bht_pkg: shared constants and types for the branch history table.
//   OP_BTYPE   : opcode of conditional (B-type) branches
//   DEF_IDX_W  : default table index width
//   DEF_CNT_W  : default saturating counter width
//   cnt_t      : counter type at the default width
package bht_pkg;
  localparam logic [6:0] OP_BTYPE  = 7'b1100011;
  localparam int         DEF_IDX_W = 6;
  localparam int         DEF_CNT_W = 2;
  typedef logic [DEF_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: combinational next-value of a W-bit saturating counter.
//   val_i : current value
//   inc_i : request +1 (holds at all-ones)
//   dec_i : request -1 (holds at zero)
//   nxt_o : saturated next value; both or neither request leaves the value unchanged
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] nxt_o
);
  localparam logic [W-1:0] MAX_V  = {W{1'b1}};
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};
  localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};

  // Saturating step selection
  always_comb begin
    nxt_o = val_i;
    if (inc_i && !dec_i) begin
      nxt_o = (val_i == MAX_V) ? val_i : val_i + ONE_V;
    end else if (dec_i && !inc_i) begin
      nxt_o = (val_i == ZERO_V) ? val_i : val_i - ONE_V;
    end else begin
      nxt_o = val_i;
    end
  end
endmodule

// File: rtl/bht_predict.sv
// bht_predict: PC-indexed table of saturating counters for branch prediction.
// IF-stage lookup is combinational; EXE-stage B-type branches train the table
// and the branch/miss statistics. Everything freezes while Istall or Dstall.
// Optional macro BHT_GSHARE_EN: XOR a global history register into the index.
// Ports:
//   clk, rst          : clock (rising), synchronous active-low reset
//   pc_IF             : fetch PC, taken_sel = prediction for it
//   opcode_ID_EXE     : EXE opcode, pc_ID_EXE : EXE PC
//   jump_sel          : resolved outcome, pred_ID_EXE : carried prediction
//   Istall, Dstall    : pipeline stalls
//   ghr_ID_EXE/ghr_IF : history snapshot in / current history out (gshare only)
//   mispredict        : combinational misprediction flag
//   br_cnt, miss_cnt  : saturating statistics
module bht_predict
  import bht_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CNT_INIT = 1,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_IF,
  output logic              taken_sel,
  input  logic [6:0]        opcode_ID_EXE,
  input  logic [PC_W-1:0]   pc_ID_EXE,
  input  logic              jump_sel,
  input  logic              pred_ID_EXE,
  input  logic              Istall,
  input  logic              Dstall,
`ifdef BHT_GSHARE_EN
  input  logic [IDX_W-1:0]  ghr_ID_EXE,
  output logic [IDX_W-1:0]  ghr_IF,
`endif
  output logic              mispredict,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] miss_cnt
);
  localparam int               DEPTH  = 1 << IDX_W;
  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(CNT_INIT);

  logic [CNT_W-1:0]  bht_q [DEPTH];
  logic [STAT_W-1:0] br_q, miss_q;
  logic [STAT_W-1:0] br_d, miss_d;
  logic [CNT_W-1:0]  entry_d;
  logic [IDX_W-1:0]  idx_lk_s, idx_up_s;
  logic              upd_s;
  logic              unused_pc_s;

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  assign idx_lk_s = pc_IF[IDX_W+1:2] ^ ghr_q;
  assign idx_up_s = pc_ID_EXE[IDX_W+1:2] ^ ghr_ID_EXE;
  assign ghr_IF   = ghr_q;
`else
  assign idx_lk_s = pc_IF[IDX_W+1:2];
  assign idx_up_s = pc_ID_EXE[IDX_W+1:2];
`endif

  // PC bits outside the index field do not take part in prediction
  assign unused_pc_s = ^{pc_IF[PC_W-1:IDX_W+2], pc_IF[1:0],
                         pc_ID_EXE[PC_W-1:IDX_W+2], pc_ID_EXE[1:0]};

  // rst is part of upd so mispredict is quiet during reset
  assign upd_s      = (opcode_ID_EXE == OP_BTYPE) && !(Istall || Dstall) && rst;
  assign mispredict = upd_s && (jump_sel != pred_ID_EXE);
  // Reads the registered table: a same-cycle update is seen one cycle later
  assign taken_sel  = bht_q[idx_lk_s][CNT_W-1];
  assign br_cnt     = br_q;
  assign miss_cnt   = miss_q;

  sat_counter #(.W(CNT_W)) u_entry (
    .val_i (bht_q[idx_up_s]),
    .inc_i (jump_sel),
    .dec_i (!jump_sel),
    .nxt_o (entry_d)
  );

  sat_counter #(.W(STAT_W)) u_br (
    .val_i (br_q),
    .inc_i (upd_s),
    .dec_i (1'b0),
    .nxt_o (br_d)
  );

  sat_counter #(.W(STAT_W)) u_miss (
    .val_i (miss_q),
    .inc_i (mispredict),
    .dec_i (1'b0),
    .nxt_o (miss_d)
  );

  // Table, history and statistics state; reset wins over a concurrent update
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i] <= INIT_V;
      end
      br_q   <= {STAT_W{1'b0}};
      miss_q <= {STAT_W{1'b0}};
`ifdef BHT_GSHARE_EN
      ghr_q  <= {IDX_W{1'b0}};
`endif
    end else if (upd_s) begin
      bht_q[idx_up_s] <= entry_d;
      br_q            <= br_d;
      miss_q          <= miss_d;
`ifdef BHT_GSHARE_EN
      ghr_q           <= {ghr_q[IDX_W-2:0], jump_sel};
`endif
    end else begin
      br_q   <= br_q;
      miss_q <= miss_q;
    end
  end
endmodule

// File: tb/tb_bht_predict.sv
// tb_bht_predict: scoreboard bench for bht_predict. A driver issues one
// stimulus per cycle, predicts the outputs from a plain-arithmetic model of
// the table and pushes them; a monitor pops and compares on the falling edge.
module tb_bht_predict;
  localparam int PC_W = 32, IDX_W = 6, CNT_W = 2, CNT_INIT = 1, STAT_W = 32;
  localparam int NENT = 64;
  localparam int CMAX = 3;
  localparam int CHALF = 2;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] ALU_OP = 7'b0110011;

  typedef struct {
    bit     taken;
    bit     mis;
    longint br;
    longint miss;
    int     ghr;
    int     cyc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [PC_W-1:0]   pc_IF;
  logic              taken_sel;
  logic [6:0]        opcode_ID_EXE;
  logic [PC_W-1:0]   pc_ID_EXE;
  logic              jump_sel;
  logic              pred_ID_EXE;
  logic              Istall;
  logic              Dstall;
  logic              mispredict;
  logic [STAT_W-1:0] br_cnt;
  logic [STAT_W-1:0] miss_cnt;
`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0]  ghr_ID_EXE;
  logic [IDX_W-1:0]  ghr_IF;
`endif

  bht_predict #(
    .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .CNT_INIT(CNT_INIT), .STAT_W(STAT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_IF         (pc_IF),
    .taken_sel     (taken_sel),
    .opcode_ID_EXE (opcode_ID_EXE),
    .pc_ID_EXE     (pc_ID_EXE),
    .jump_sel      (jump_sel),
    .pred_ID_EXE   (pred_ID_EXE),
    .Istall        (Istall),
    .Dstall        (Dstall),
`ifdef BHT_GSHARE_EN
    .ghr_ID_EXE    (ghr_ID_EXE),
    .ghr_IF        (ghr_IF),
`endif
    .mispredict    (mispredict),
    .br_cnt        (br_cnt),
    .miss_cnt      (miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  int     m_cnt [NENT];
  longint m_br, m_miss;
  int     m_ghr;
  bit     m_valid;
  int     cyc;

  exp_t   sb_q [$];
  int     total;
  int     bad;
  bit     done;

  task automatic chk(input string name, input int c, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
    end
  endtask

  // monitor: compare the outputs presented this cycle with the predicted ones
  initial begin
    exp_t e;
    total = 0;
    bad = 0;
    while (!done) begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("taken_sel", e.cyc, longint'(taken_sel), longint'(e.taken));
        chk("mispredict", e.cyc, longint'(mispredict), longint'(e.mis));
        chk("br_cnt", e.cyc, longint'(br_cnt), e.br);
        chk("miss_cnt", e.cyc, longint'(miss_cnt), e.miss);
`ifdef BHT_GSHARE_EN
        chk("ghr_IF", e.cyc, longint'(ghr_IF), longint'(e.ghr));
`endif
      end
    end
  end

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  // one cycle of stimulus; expectations are pushed, then the model advances
  task automatic step(input bit r, input logic [PC_W-1:0] pif, input logic [6:0] op,
                      input logic [PC_W-1:0] pex, input bit j, input bit pr,
                      input bit is, input bit ds, input int gex);
    exp_t e;
    bit   upd;
    int   li, ui;
    @(posedge clk);
    #1;
    rst = r; pc_IF = pif; opcode_ID_EXE = op; pc_ID_EXE = pex;
    jump_sel = j; pred_ID_EXE = pr; Istall = is; Dstall = ds;
`ifdef BHT_GSHARE_EN
    ghr_ID_EXE = IDX_W'(gex);
    li = idx_of(pif) ^ m_ghr;
    ui = idx_of(pex) ^ gex;
`else
    li = idx_of(pif);
    ui = idx_of(pex) + (gex & 0);
`endif
    upd = r && (op == BR_OP) && !(is || ds);
    cyc++;
    if (m_valid) begin
      e.taken = (m_cnt[li] >= CHALF);
      e.mis   = upd && (j != pr);
      e.br    = m_br;
      e.miss  = m_miss;
      e.ghr   = m_ghr;
      e.cyc   = cyc;
      sb_q.push_back(e);
    end
    if (!r) begin
      foreach (m_cnt[k]) m_cnt[k] = CNT_INIT;
      m_br = 0; m_miss = 0; m_ghr = 0; m_valid = 1'b1;
    end else if (upd) begin
      if (j) m_cnt[ui] = (m_cnt[ui] == CMAX) ? CMAX : m_cnt[ui] + 1;
      else   m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
      if (m_br < (64'd1 << STAT_W) - 1) m_br++;
      if (j != pr && m_miss < (64'd1 << STAT_W) - 1) m_miss++;
      m_ghr = ((m_ghr << 1) | int'(j)) % NENT;
    end
  endtask

  // idle cycle with a lookup only
  task automatic look(input logic [PC_W-1:0] pif);
    step(1'b1, pif, ALU_OP, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, m_ghr);
  endtask

  // B-type resolution at pex with lookup at pif
  task automatic br(input logic [PC_W-1:0] pif, input logic [PC_W-1:0] pex,
                    input bit j, input bit pr);
    step(1'b1, pif, BR_OP, pex, j, pr, 1'b0, 1'b0, m_ghr);
  endtask

  initial begin
    done = 1'b0; m_valid = 1'b0; cyc = 0; m_ghr = 0; m_br = 0; m_miss = 0;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    rst = 1'b0; pc_IF = 32'h0; opcode_ID_EXE = 7'h0; pc_ID_EXE = 32'h0;
    jump_sel = 1'b0; pred_ID_EXE = 1'b0; Istall = 1'b0; Dstall = 1'b0;
`ifdef BHT_GSHARE_EN
    ghr_ID_EXE = 6'h0;
`endif
    // reset for two edges, then sweep every index
    step(1'b0, 32'h0, ALU_OP, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 32'h0, ALU_OP, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int a = 0; a < 256; a += 4) look(32'(a));
    // training at 0x40: saturate, then walk back down
    for (int n = 0; n < 4; n++) br(32'h40, 32'h40, 1'b1, 1'b1);
    look(32'h40);
    br(32'h40, 32'h40, 1'b0, 1'b1);
    br(32'h40, 32'h40, 1'b0, 1'b1);
    look(32'h40);
    // aliasing and isolation
    br(32'h44, 32'h40, 1'b1, 1'b0);
    look(32'h140);
    look(32'h44);
    look(32'h40);
    // same-cycle lookup and update of one index
    br(32'h80, 32'h80, 1'b1, 1'b0);
    look(32'h80);
    // stalls hold everything, then the branch completes
    step(1'b1, 32'hC0, BR_OP, 32'hC0, 1'b1, 1'b0, 1'b1, 1'b0, m_ghr);
    step(1'b1, 32'hC0, BR_OP, 32'hC0, 1'b1, 1'b0, 1'b0, 1'b1, m_ghr);
    step(1'b1, 32'hC0, BR_OP, 32'hC0, 1'b1, 1'b0, 1'b1, 1'b1, m_ghr);
    br(32'hC0, 32'hC0, 1'b1, 1'b0);
    look(32'hC0);
    // non-branch opcode does nothing
    step(1'b1, 32'hC4, ALU_OP, 32'hC4, 1'b1, 1'b0, 1'b0, 1'b0, m_ghr);
    look(32'hC4);
    // reset concurrent with an update
    step(1'b0, 32'h100, BR_OP, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, m_ghr);
    look(32'h100);
    // history pattern taken, taken, not-taken, then lookup of 0x40
    br(32'h0, 32'h200, 1'b1, 1'b1);
    br(32'h0, 32'h204, 1'b1, 1'b1);
    br(32'h0, 32'h208, 1'b0, 1'b1);
    look(32'h40);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [PC_W-1:0] a, b;
      a = {$urandom_range(0, 3) << 10} | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      b = {$urandom_range(0, 3) << 10} | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      step(($urandom_range(0, 99) != 0), a,
           ($urandom_range(0, 9) < 6) ? BR_OP : 7'($urandom),
           b, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : m_ghr);
    end
    look(32'h40);
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d expected=0", sb_q.size());
    end
    done = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bht_predict.md
Name: bht_predict

Overview:
- PC-indexed branch history table (BHT) of 2^IDX_W saturating counters, each CNT_W bits wide.
- Replaces the single global 2-bit predictor.
- IF-stage lookup gives taken_sel. EXE-stage resolution of B-type branches trains the table, flags mispredictions and maintains branch/miss statistics.
- Table and statistics update are frozen on Istall || Dstall.

Parameters:
- PC_W, 32, PC width.
- IDX_W, 6, table index bits (64 entries); index = pc[IDX_W+1:2].
- CNT_W, 2, counter width (>=1).
- CNT_INIT, 1, reset value of every counter (weakly not-taken for CNT_W=2).
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a clk rising edge resets).
- pc_IF  in  PC_W  fetch PC for lookup.
- taken_sel  out  1  prediction for pc_IF.
- opcode_ID_EXE  in  7  EXE-stage opcode; training only when equal to `Btype.
- pc_ID_EXE  in  PC_W  PC of the EXE-stage instruction.
- jump_sel  in  1  resolved outcome (1 = taken).
- pred_ID_EXE  in  1  prediction carried with the EXE-stage instruction.
- Istall  in  1  instruction-memory stall.
- Dstall  in  1  data-memory stall.
- mispredict  out  1  EXE B-type outcome differs from pred_ID_EXE.
- br_cnt  out  STAT_W  resolved B-type branches.
- miss_cnt  out  STAT_W  mispredicted B-type branches.

Behaviour:
- upd = (opcode_ID_EXE==`Btype) && !(Istall||Dstall) && rst.
- Lookup is combinational: taken_sel = MSB of table[idx(pc_IF)].
- Update, registered at the clk edge when upd: table[idx(pc_ID_EXE)] increments if jump_sel, else decrements.
  - Saturates at 2^CNT_W-1 and at 0. No wrap.
- Same-cycle lookup and update to the same index: taken_sel shows the pre-update value. No bypass. The new value is visible the cycle after the edge.
- Updates to different indices never disturb other entries.
- mispredict = upd && (jump_sel != pred_ID_EXE). Combinational, 0 while stalled or while rst==0.
- Statistics:
  - br_cnt += 1 on every upd.
  - miss_cnt += 1 when mispredict.
  - Both saturate at all-ones.
- Reset: on any edge with rst==0, including mid-operation, all entries are set to CNT_INIT and br_cnt and miss_cnt are cleared.
  - After reset: taken_sel=0 (CNT_INIT MSB=0), mispredict=0, br_cnt=0, miss_cnt=0.
  - Reset overrides a concurrent update.
- Stall held for N cycles: table, history and statistics hold for all N. Lookup stays live.

Optional Feature:
- Macro BHT_GSHARE_EN.
- Defined:
  - Add an IDX_W-bit global history register ghr, reset to 0.
  - Lookup index = pc_IF[IDX_W+1:2] ^ ghr.
  - Update index = pc_ID_EXE[IDX_W+1:2] ^ ghr_ID_EXE, where ghr_ID_EXE is an extra input port carrying the ghr snapshot taken at fetch.
  - On upd: ghr <= {ghr[IDX_W-2:0], jump_sel}.
  - Extra output ghr_IF (IDX_W bits) exposes ghr for pipelining.
- Undefined: pure PC indexing; no ghr_ID_EXE/ghr_IF ports; behaviour as above.

Decomposition:
- Shared package bht_pkg (or additions to define.sv): `Btype opcode constant, default IDX_W/CNT_W, and the counter typedef logic [CNT_W-1:0].
- One sub-module, sat_counter:
  - Parameterised by CNT_W and STAT-style saturation.
  - Inputs: inc/dec enable.
  - Output: saturated next value.
  - Used for the table-entry next-state and for both statistics counters (increment-only instance).

Test Plan:
- Reset: hold rst=0 two edges, release.
  - Every pc_IF in 0x000-0x0FC returns taken_sel=0.
  - br_cnt=miss_cnt=0.
- Training: B-type at pc 0x40, jump_sel=1 for 3 upd cycles.
  - taken_sel for pc_IF=0x40 goes 0→1 after the first edge.
  - Counter saturates at 3; a 4th taken keeps 3.
  - Two not-taken updates then return taken_sel to 0.
- Aliasing/isolation: update 0x40 taken.
  - 0x140 (same index at IDX_W=6) predicts 1.
  - 0x44 still predicts 0.
- Same-cycle hazard: pc_IF=pc_ID_EXE=0x80, upd taken from CNT_INIT.
  - taken_sel=0 in that cycle, 1 next cycle.
- Stall and statistics: Istall=1 during a B-type with pred_ID_EXE=0, jump_sel=1.
  - mispredict=0, no counter or table change.
  - Deassert: mispredict=1, br_cnt=1, miss_cnt=1.
  - Non-B-type opcode: no change.
- Mid-operation reset and BHT_GSHARE_EN:
  - rst=0 concurrent with upd: table stays at CNT_INIT.
  - With BHT_GSHARE_EN, after taken,taken,not-taken: ghr=3'b110 in the low bits, and lookup of 0x40 uses index 0x10^0x06.
